// File: rtl/memory_responder.sv
// memory_responder
//   Responder end of the MFA/MOC memory handshake. A request seen in IDLE is
//   captured. After WAIT_CYCLES extra edges, a byte-addressed big-endian RAM
//   access is performed and MOC is raised. MOC stays high until MFA drops.
//
//   Ports
//     clk       rising-edge clock
//     reset     asynchronous active-low reset
//     MFA       request (memory function activate)
//     RW        1 = read, 0 = write
//     DataSize  00 byte, 01 halfword, 1x word
//     Address   byte address; only the low log2(DEPTH) bits are used
//     DataIn    write data, right-justified
//     DataOut   last read data, zero-extended, right-justified
//     MOC       memory operation complete
//     Abort     misaligned-access flag
//
//   Optional build macro MEMORY_RESPONDER_MISALIGN_ABORT_EN:
//     When defined, misaligned halfword and word accesses are suppressed and
//     are flagged on Abort alongside MOC.
//     When undefined, addresses are silently aligned and Abort is tied to 0.

module memory_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        DataSize,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Abort
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            r_moc, w_moc_nxt;
  logic            w_capture, w_access;

  // request captured at acceptance; inputs are ignored until the next IDLE
  logic            r_rw;
  logic [1:0]      r_size;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_din;
  logic [31:0]     r_dout;

  logic [7:0]      r_mem [DEPTH];

  logic            w_half, w_word, w_misalign, w_wr, w_rd;
  logic [AW-1:0]   w_a0, w_a1, w_a2, w_a3;
  logic [31:0]     w_rdata;

  // only the low AW address bits index the array
  logic            w_unused_addr;
  assign w_unused_addr = ^Address[ADDR_W-1:AW];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_moc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_moc   <= w_moc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_moc_nxt   = r_moc;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MFA) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_moc_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!MFA) begin
          w_moc_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_moc_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign MOC = r_moc;

  // ---------------- request capture ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rw   <= 1'b0;
      r_size <= 2'b00;
      r_addr <= '0;
      r_din  <= 32'd0;
    end else if (w_capture) begin
      r_rw   <= RW;
      r_size <= DataSize;
      r_addr <= Address[AW-1:0];
      r_din  <= DataIn;
    end
  end

  // ---------------- address generation ----------------
  assign w_half = (r_size == 2'b01);
  assign w_word = r_size[1];              // 11 behaves as word

  always_comb begin
    w_a0 = r_addr;
    if (w_word)      w_a0 = {r_addr[AW-1:2], 2'b00};
    else if (w_half) w_a0 = {r_addr[AW-1:1], 1'b0};
  end

  // byte lanes wrap modulo DEPTH through AW-bit arithmetic
  assign w_a1 = w_a0 + AW'(1);
  assign w_a2 = w_a0 + AW'(2);
  assign w_a3 = w_a0 + AW'(3);

`ifdef MEMORY_RESPONDER_MISALIGN_ABORT_EN
  assign w_misalign = (w_half & r_addr[0]) | (w_word & (|r_addr[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_wr = w_access & ~r_rw & ~w_misalign;
  assign w_rd = w_access &  r_rw & ~w_misalign;

  // ---------------- storage (not reset) ----------------
  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (w_word) begin
        r_mem[w_a0] <= r_din[31:24];
        r_mem[w_a1] <= r_din[23:16];
        r_mem[w_a2] <= r_din[15:8];
        r_mem[w_a3] <= r_din[7:0];
      end else if (w_half) begin
        r_mem[w_a0] <= r_din[15:8];
        r_mem[w_a1] <= r_din[7:0];
      end else begin
        r_mem[w_a0] <= r_din[7:0];
      end
    end
  end

  // big-endian: lowest address lands in the most significant used byte
  always_comb begin
    w_rdata = {24'd0, r_mem[w_a0]};
    if (w_word)      w_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
    else if (w_half) w_rdata = {16'd0, r_mem[w_a0], r_mem[w_a1]};
  end

  // DataOut only moves on a completed read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_dout <= 32'd0;
    else if (w_rd) r_dout <= w_rdata;
  end

  assign DataOut = r_dout;

  // ---------------- abort flag ----------------
`ifdef MEMORY_RESPONDER_MISALIGN_ABORT_EN
  logic r_abort;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_abort <= 1'b0;
    else if (w_access)                   r_abort <= w_misalign;
    else if (r_state == S_DONE && !MFA)  r_abort <= 1'b0;
  end
  assign Abort = r_abort;
`else
  assign Abort = 1'b0;
`endif

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

  logic        clk;
  logic        reset;
  logic        MFA;
  logic        RW;
  logic [1:0]  DataSize;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Abort;

  int n_vec = 0;
  int n_err = 0;

  memory_responder #(.DEPTH(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .MFA      (MFA),
    .RW       (RW),
    .DataSize (DataSize),
    .Address  (Address),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .MOC      (MOC),
    .Abort    (Abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full handshake: raise MFA, wait for MOC, drop MFA, confirm MOC falls.
  task automatic op(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d, output int lat, output logic ab);
    @(negedge clk);
    MFA = 1'b1; RW = rw; DataSize = sz; Address = a; DataIn = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (MOC !== 1'b1 && lat < 20);
    ab = Abort;
    @(negedge clk);
    // scramble the request inputs; captured values must be used
    MFA = 1'b0; RW = ~rw; Address = 32'hFFFF_FFFF; DataIn = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("moc_drop", {31'd0, MOC}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   hi;
    logic ab;

    reset = 1'b0; MFA = 1'b0; RW = 1'b0; DataSize = 2'b00;
    Address = 32'd0; DataIn = 32'd0;
    #12 reset = 1'b1;

    // reset then idle
    repeat (5) begin
      @(negedge clk);
      chk("idle_moc", {31'd0, MOC}, 32'd0);
      chk("idle_dout", DataOut, 32'h0000_0000);
    end

    // word write, latency = WAIT_CYCLES + 2 edges
    op(1'b0, 2'b10, 32'h10, 32'hDEAD_BEEF, lat, ab);
    chk("wr_word_lat", 32'(lat), 32'd4);
    chk("wr_keeps_dout", DataOut, 32'h0000_0000);
    chk("abort_off", {31'd0, ab}, 32'd0);

    op(1'b1, 2'b00, 32'h10, 32'h0, lat, ab);
    chk("rd_byte_lat", 32'(lat), 32'd4);
    chk("rd_byte_10", DataOut, 32'h0000_00DE);
    op(1'b1, 2'b00, 32'h13, 32'h0, lat, ab);
    chk("rd_byte_13", DataOut, 32'h0000_00EF);
    op(1'b1, 2'b01, 32'h12, 32'h0, lat, ab);
    chk("rd_half_12", DataOut, 32'h0000_BEEF);
    op(1'b1, 2'b01, 32'h13, 32'h0, lat, ab);
    chk("rd_half_13_align", DataOut, 32'h0000_BEEF);

    // byte write over existing word
    op(1'b0, 2'b00, 32'h11, 32'hFFFF_FFA5, lat, ab);
    chk("wr_byte_keeps_dout", DataOut, 32'h0000_BEEF);
    op(1'b1, 2'b10, 32'h10, 32'h0, lat, ab);
    chk("rd_word_10", DataOut, 32'hDEA5_BEEF);
    op(1'b1, 2'b11, 32'h11, 32'h0, lat, ab);
    chk("rd_size11_word", DataOut, 32'hDEA5_BEEF);

    // MFA held 6 cycles past MOC
    @(negedge clk);
    MFA = 1'b1; RW = 1'b1; DataSize = 2'b01; Address = 32'h10;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (MOC !== 1'b1 && lat < 20);
    chk("hold_lat", 32'(lat), 32'd4);
    Address = 32'h80;
    repeat (6) begin
      @(negedge clk);
      chk("hold_moc_high", {31'd0, MOC}, 32'd1);
    end
    MFA = 1'b0;
    @(posedge clk); #1;
    chk("hold_moc_drop", {31'd0, MOC}, 32'd0);
    chk("hold_dout", DataOut, 32'h0000_DEA5);

    // MFA pulsed for one cycle: MOC high exactly one cycle
    @(negedge clk);
    MFA = 1'b1; RW = 1'b1; DataSize = 2'b00; Address = 32'h11;
    @(negedge clk);
    MFA = 1'b0;
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (MOC === 1'b1) hi++;
    end
    chk("pulse_moc_width", 32'(hi), 32'd1);
    chk("pulse_dout", DataOut, 32'h0000_00A5);

    // reset during BUSY abandons the write
    op(1'b0, 2'b10, 32'h20, 32'hCAFE_F00D, lat, ab);
    @(negedge clk);
    MFA = 1'b1; RW = 1'b0; DataSize = 2'b10; Address = 32'h20; DataIn = 32'h1234_5678;
    @(negedge clk);
    reset = 1'b0; MFA = 1'b0;
    #3;
    chk("rst_dout", DataOut, 32'h0000_0000);
    chk("rst_moc", {31'd0, MOC}, 32'd0);
    reset = 1'b1;
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (MOC === 1'b1) hi++;
    end
    chk("rst_no_moc", 32'(hi), 32'd0);
    op(1'b1, 2'b10, 32'h20, 32'h0, lat, ab);
    chk("rst_mem_kept", DataOut, 32'hCAFE_F00D);

    // wrap and alignment
    op(1'b0, 2'b10, 32'hFC, 32'hAABB_CCDD, lat, ab);
    op(1'b0, 2'b10, 32'h1FE, 32'h0102_0304, lat, ab);
    chk("mis_lat", 32'(lat), 32'd4);
`ifdef MEMORY_RESPONDER_MISALIGN_ABORT_EN
    chk("mis_abort", {31'd0, ab}, 32'd1);
    chk("mis_abort_clr", {31'd0, Abort}, 32'd0);
    op(1'b1, 2'b10, 32'hFC, 32'h0, lat, ab);
    chk("mis_mem_unchanged", DataOut, 32'hAABB_CCDD);
`else
    chk("wrap_abort_off", {31'd0, ab}, 32'd0);
    op(1'b1, 2'b10, 32'hFC, 32'h0, lat, ab);
    chk("wrap_rd_word_fc", DataOut, 32'h0102_0304);
    op(1'b1, 2'b00, 32'hFF, 32'h0, lat, ab);
    chk("wrap_rd_byte_ff", DataOut, 32'h0000_0004);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
